// File: rtl/cacheline_adaptor_if.sv
// Cache/memory handshake bundle for cacheline_adaptor: line-side request signals and
// beat-side burst signals. The slave modport is the adaptor; the master modport drives it.
interface cacheline_adaptor_if #(
  parameter int unsigned BURST_W = 64,
  parameter int unsigned BEATS   = 4
);
  localparam int unsigned LINE_W = BURST_W * BEATS;

  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits cacheline writes into BEATS memory bursts and assembles read bursts into a line.
// Optional macro CACHELINE_ADAPTOR_ALIGN_EN forces the burst address to line alignment.
module cacheline_adaptor #(
  parameter int unsigned BURST_W = 64,
  parameter int unsigned BEATS   = 4
) (
  input logic                 clk,
  input logic                 rst,
  cacheline_adaptor_if.slave  bus
);
  localparam int unsigned LINE_W = BURST_W * BEATS;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    Idle,
    RdBurst,
    RdDone,
    WrBurst,
    WrDone
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  // Read and write lines are kept apart so a write never disturbs line_o.
  logic [LINE_W-1:0] rbuf_q, rbuf_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [31:0]       addr_out;
  logic              last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
    unique case (state_q)
      Idle: begin
        if (bus.read_i && !bus.write_i) begin
          addr_d  = bus.address_i;
          cnt_d   = '0;
          state_d = RdBurst;
        end else if (bus.write_i && !bus.read_i) begin
          addr_d  = bus.address_i;
          wbuf_d  = bus.line_i;
          cnt_d   = '0;
          state_d = WrBurst;
        end
      end
      RdBurst: begin
        if (bus.resp_i) begin
          rbuf_d[cnt_q*BURST_W +: BURST_W] = bus.burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = RdDone;
        end
      end
      WrBurst: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = WrDone;
        end
      end
      RdDone, WrDone: state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Idle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
    end
  end

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  assign addr_out = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
`else
  assign addr_out = addr_q;
`endif

  // Outputs decode only flopped state, so reset clears them asynchronously.
  always_comb begin
    bus.read_o    = (state_q == RdBurst);
    bus.write_o   = (state_q == WrBurst);
    bus.resp_o    = (state_q == RdDone) || (state_q == WrDone);
    bus.address_o = ((state_q == RdBurst) || (state_q == WrBurst)) ? addr_out : '0;
    bus.burst_o   = '0;
    if (state_q == WrBurst) bus.burst_o = wbuf_q[cnt_q*BURST_W +: BURST_W];
    bus.line_o    = rbuf_q;
  end
endmodule
